// File: rtl/n_1_mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// n_1_mux_rr_arbiter
//   Round-robin arbiter that shares one N:1 mux channel among X = 2**N
//   requesters. Each capture picks one requesting slot and registers its
//   data word. The word is offered downstream over a valid/ready handshake.
//   The select is exported on s_line so that an external mux can follow
//   the same decision.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-slot request, bit i = slot i holds a word
//   data_in    packed slot data, slot i at [i*DW +: DW]
//   gnt        one-hot, one-cycle pulse: slot's current word was taken
//   s_line     registered select of the current/last winner
//   out_valid  out_data is valid
//   out_data   registered captured word
//   out_ready  downstream accepts out_data when out_valid && out_ready
//   busy       out_valid or any request pending
// ----------------------------------------------------------------------------
module n_1_mux_rr_arbiter #(
  parameter int N  = 3,
  parameter int X  = 2**N,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [X-1:0]    req,
  input  logic [X*DW-1:0] data_in,
  output logic [X-1:0]    gnt,
  output logic [N-1:0]    s_line,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready,
  output logic            busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state_p0, state_nxt;
  logic [N-1:0]   ptr_p0;
  logic [X-1:0]   eff_req;
  logic           win_vld;
  logic [N-1:0]   win_idx;
  logic           load;

  // A slot whose grant is high this cycle is presenting its next word (or
  // dropping req); masking it stops the same word being captured twice.
  assign eff_req = req & ~gnt;

  // First set bit of eff_req searching upward from ptr, wrapping X-1 -> 0.
  always_comb begin : arb
    logic [N-1:0] idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int i = 0; i < X; i++) begin
      idx = ptr_p0 + N'(i);
      if (!win_vld && eff_req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  // A capture happens whenever the output register is free or being drained.
  always_comb begin
    state_nxt = state_p0;
    load      = 1'b0;
    case (state_p0)
      IDLE: begin
        if (win_vld) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (win_vld) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: state, pointer and captured output ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      ptr_p0   <= '0;
      gnt      <= '0;
      s_line   <= '0;
      out_data <= '0;
    end else begin
      state_p0 <= state_nxt;
      gnt      <= '0;
      if (load) begin
        ptr_p0   <= win_idx + N'(1);
        gnt      <= {{(X-1){1'b0}}, 1'b1} << win_idx;
        s_line   <= win_idx;
        out_data <= data_in[int'(win_idx)*DW +: DW];
      end
    end
  end

  assign out_valid = (state_p0 == HOLD);
  assign busy      = out_valid | (|req);

endmodule

// File: tb/tb_n_1_mux_rr_arbiter.sv
module tb_n_1_mux_rr_arbiter;

  localparam int N  = 3;
  localparam int X  = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [X-1:0]    req;
  logic [X*DW-1:0] data_in;
  logic [X-1:0]    gnt;
  logic [N-1:0]    s_line;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic            busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         v;
    logic [X-1:0] g;
    logic [N-1:0] s;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];

  n_1_mux_rr_arbiter #(.N(N), .X(X), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .s_line    (s_line),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic void push(input logic v, input logic [X-1:0] g,
                               input logic [N-1:0] s, input logic [DW-1:0] d);
    exp_t e;
    e.v = v; e.g = g; e.s = s; e.d = d;
    sb.push_back(e);
  endfunction

  task automatic set_default_data();
    for (int i = 0; i < X; i++) data_in[i*DW +: DW] = 8'(16 + i);
  endtask

  // Apply inputs for one cycle, then sample just after the rising edge.
  task automatic drive(input logic [X-1:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; req = '0; out_ready = 1'b0; set_default_data();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || gnt !== '0 || s_line !== '0 || out_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b g=%h s=%0d d=%h busy=%b, required all 0",
               out_valid, gnt, s_line, out_data, busy);
    end
    rst_n = 1'b1;
    // capture slot 0, then stall
    push(1'b1, 8'h01, 3'd0, 8'h10);
    push(1'b1, 8'h00, 3'd0, 8'h10);
    for (int c = 0; c < 2; c++) begin
      drive(8'hFF, 1'b0);
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || gnt !== e.g || s_line !== e.s || out_data !== e.d) begin
        errors++;
        $display("FAIL reset_pre cyc%0d: got v=%b g=%h s=%0d d=%h, required v=%b g=%h s=%0d d=%h",
                 c, out_valid, gnt, s_line, out_data, e.v, e.g, e.s, e.d);
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_hold: got %b, required 1", busy);
    end
    // mid-HOLD asynchronous reset, checked with no clock edge in between
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || gnt !== '0 || s_line !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b g=%h s=%0d d=%h, required all 0",
               out_valid, gnt, s_line, out_data);
    end
    #1;
    rst_n = 1'b1;
    push(1'b1, 8'h01, 3'd0, 8'h10);
    push(1'b0, 8'h00, 3'd0, 8'h10);
    for (int c = 0; c < 2; c++) begin
      drive((c == 0) ? 8'hFF : 8'h00, 1'b1);
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || gnt !== e.g || s_line !== e.s || out_data !== e.d) begin
        errors++;
        $display("FAIL reset_post cyc%0d: got v=%b g=%h s=%0d d=%h, required v=%b g=%h s=%0d d=%h",
                 c, out_valid, gnt, s_line, out_data, e.v, e.g, e.s, e.d);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    data_in[2*DW +: DW] = 8'hA5;
    push(1'b1, 8'h04, 3'd2, 8'hA5);
    push(1'b0, 8'h00, 3'd2, 8'hA5);
    for (int c = 0; c < 2; c++) begin
      drive((c == 0) ? 8'h04 : 8'h00, 1'b1);
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || gnt !== e.g || s_line !== e.s || out_data !== e.d) begin
        errors++;
        $display("FAIL single cyc%0d: got v=%b g=%h s=%0d d=%h, required v=%b g=%h s=%0d d=%h",
                 c, out_valid, gnt, s_line, out_data, e.v, e.g, e.s, e.d);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: got %b, required 0", busy);
    end
    set_default_data();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    pulse_reset();
    for (int i = 0; i < 9; i++) push(1'b1, 8'(1 << (i % 8)), 3'(i % 8), 8'(16 + (i % 8)));
    push(1'b0, 8'h00, 3'd0, 8'h10);
    for (int c = 0; c < 10; c++) begin
      drive((c < 9) ? 8'hFF : 8'h00, 1'b1);
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || gnt !== e.g || s_line !== e.s || out_data !== e.d) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got v=%b g=%h s=%0d d=%h, required v=%b g=%h s=%0d d=%h",
                 c, out_valid, gnt, s_line, out_data, e.v, e.g, e.s, e.d);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    pulse_reset();
    push(1'b1, 8'h01, 3'd0, 8'h10);
    for (int i = 0; i < 5; i++) push(1'b1, 8'h00, 3'd0, 8'h10);
    push(1'b1, 8'h02, 3'd1, 8'h11);
    push(1'b0, 8'h00, 3'd1, 8'h11);
    for (int c = 0; c < 8; c++) begin
      drive((c < 7) ? 8'hFF : 8'h00, (c >= 6));
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || gnt !== e.g || s_line !== e.s || out_data !== e.d) begin
        errors++;
        $display("FAIL backpressure cyc%0d: got v=%b g=%h s=%0d d=%h, required v=%b g=%h s=%0d d=%h",
                 c, out_valid, gnt, s_line, out_data, e.v, e.g, e.s, e.d);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [X-1:0] reqs_a [4] = '{8'h80, 8'h81, 8'h81, 8'h00};
    logic [X-1:0] reqs_b [4] = '{8'h40, 8'h81, 8'h81, 8'h00};
    // grant to slot 7 leaves ptr=0: slot 0 then 7
    pulse_reset();
    push(1'b1, 8'h80, 3'd7, 8'h17);
    push(1'b1, 8'h01, 3'd0, 8'h10);
    push(1'b1, 8'h80, 3'd7, 8'h17);
    push(1'b0, 8'h00, 3'd7, 8'h17);
    for (int c = 0; c < 4; c++) begin
      drive(reqs_a[c], 1'b1);
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || gnt !== e.g || s_line !== e.s || out_data !== e.d) begin
        errors++;
        $display("FAIL wrap_ptr0 cyc%0d: got v=%b g=%h s=%0d d=%h, required v=%b g=%h s=%0d d=%h",
                 c, out_valid, gnt, s_line, out_data, e.v, e.g, e.s, e.d);
      end
    end
    // grant to slot 6 leaves ptr=7: slot 7 then 0
    pulse_reset();
    push(1'b1, 8'h40, 3'd6, 8'h16);
    push(1'b1, 8'h80, 3'd7, 8'h17);
    push(1'b1, 8'h01, 3'd0, 8'h10);
    push(1'b0, 8'h00, 3'd0, 8'h10);
    for (int c = 0; c < 4; c++) begin
      drive(reqs_b[c], 1'b1);
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || gnt !== e.g || s_line !== e.s || out_data !== e.d) begin
        errors++;
        $display("FAIL wrap_ptr7 cyc%0d: got v=%b g=%h s=%0d d=%h, required v=%b g=%h s=%0d d=%h",
                 c, out_valid, gnt, s_line, out_data, e.v, e.g, e.s, e.d);
      end
    end
  endtask

  task automatic test_masking();
    exp_t e;
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(1'b1, 8'h08, 3'd3, 8'h13);
      else            push(1'b0, 8'h00, 3'd3, 8'h13);
    end
    push(1'b0, 8'h00, 3'd3, 8'h13);
    for (int c = 0; c < 7; c++) begin
      drive((c < 6) ? 8'h08 : 8'h00, 1'b1);
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || gnt !== e.g || s_line !== e.s || out_data !== e.d) begin
        errors++;
        $display("FAIL masking cyc%0d: got v=%b g=%h s=%0d d=%h, required v=%b g=%h s=%0d d=%h",
                 c, out_valid, gnt, s_line, out_data, e.v, e.g, e.s, e.d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_masking();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/n_1_mux_rr_arbiter.md
Name: n_1_mux_rr_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one N:1 mux output channel among X = 2**N requesters.
- Each cycle it selects one requesting slot and drives the mux select (s_line). It captures the selected data word into an output register and presents it downstream with a valid/ready handshake.
- Sits directly in front of n_1_mux_rtl-style datapaths; s_line is exported so an external mux instance can be slaved to the same decision.

Parameters:
- N, 3, select width; number of requesters X = 2**N.
- X, 2**N, derived requester count; not overridden independently.
- DW, 8, data width per requester slot.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  X  per-slot request; bit i high means slot i holds a word.
- data_in  input  X*DW  packed slot data; slot i occupies bits [i*DW +: DW].
- gnt  output  X  one-hot, registered, one-cycle pulse: slot's current word has been taken.
- s_line  output  N  registered select of the current/last winner.
- out_valid  output  1  registered; out_data is valid.
- out_data  output  DW  registered captured word.
- out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high.
- busy  output  1  high while out_valid is high or any req bit is high.

Behaviour:
- Reset (async, rst_n=0): s_line=0, out_data=0, out_valid=0, gnt=0, priority pointer ptr=0, FSM=IDLE. Reset takes effect immediately, including mid-transfer; the pending word is dropped.
- FSM states:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
- Arbitration (combinational):
  - Winner is the first set bit of the effective request vector, searching from index ptr upward and wrapping X-1 -> 0.
  - Effective request = req with the slot whose gnt is currently high masked off.
  - No effective request means no winner.
- IDLE, winner w exists: at the clock edge, s_line<=w, out_data<=data_in slice w, out_valid<=1, gnt<=onehot(w), ptr<=(w+1) mod X, next state HOLD.
- IDLE, no winner: remain IDLE; gnt<=0.
- HOLD, out_ready=0: hold s_line, out_data and out_valid stable; gnt<=0; no re-arbitration.
- HOLD, out_ready=1 (handshake):
  - If a winner exists, capture it exactly as in IDLE and stay in HOLD. This gives back-to-back transfers, one word per cycle.
  - Otherwise out_valid<=0, gnt<=0, next state IDLE. s_line and out_data keep their last values.
- Latency: req high in cycle t (IDLE) -> out_valid, gnt and s_line update in cycle t+1.
- Requester contract:
  - In the cycle its gnt is high, a requester either drops req or presents its next word.
  - Its req is ignored in that cycle (masking), so a held req cannot be double-captured.
  - A single continuously requesting slot is therefore served at most every other cycle.
- Fairness: a slot waits at most X-1 grants to other slots.
- ptr wraps modulo X (7 -> 0 for N=3). The only arithmetic is N-bit unsigned increment with natural wrap.
- gnt is never high for more than one cycle per capture and never has more than one bit set.

Test Plan (N=3, DW=8):
1. Drive req=8'hFF, start a transfer, hold out_ready=0, then pull rst_n low mid-HOLD -> out_valid, gnt, s_line and out_data go to 0 asynchronously; after release, first grant goes to slot 0.
2. Drive req=8'b0000_0100, slot2 data=8'hA5, out_ready=1 -> next cycle gnt=8'b0000_0100, s_line=2, out_data=8'hA5, out_valid=1 for one cycle; then IDLE with out_valid=0.
3. Drive req=8'hFF (each slot i data = 8'h10+i), out_ready=1 every cycle -> s_line sequence 0,1,2,...,7,0 on consecutive cycles, out_data 8'h10..8'h17, one gnt bit per cycle.
4. Start a transfer, then hold out_ready=0 for 5 cycles with req=8'hFF -> out_valid=1 with s_line/out_data unchanged for all 5 cycles, gnt=0 after the capture cycle; on out_ready=1 the next slot is granted the following cycle.
5. Wrap-around: after a grant to slot 7 (ptr=0), drive req=8'b1000_0001 -> grants go to slot 0 then slot 7. With ptr=7 and the same req -> slot 7 then slot 0.
6. Hold req=8'b0000_1000 continuously, out_ready=1 -> gnt[3] pulses every other cycle (masking rule) and out_valid toggles 1,0,1,0 with s_line=3.
